// File: rtl/vector_sweep_ctrl.sv
// rtl/vector_sweep_ctrl.sv - exhaustive operand sweep comparing reference and DUT outputs under a care mask
// Optional macro STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module vector_sweep_ctrl #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] care_mask,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic [IN_W-1:0]  dut_a,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IN_W-1:0]  fail_vec,
  output logic [OUT_W-1:0] fail_ref,
  output logic [OUT_W-1:0] fail_dut,
  output logic [15:0]      err_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0]   mask_q, mask_d;
  logic [IN_W-1:0]    dut_a_q, dut_a_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mismatch_q, mismatch_d;
  logic [IN_W-1:0]    fail_vec_q, fail_vec_d;
  logic [OUT_W-1:0]   fail_ref_q, fail_ref_d;
  logic [OUT_W-1:0]   fail_dut_q, fail_dut_d;
  logic [15:0]        err_count_q, err_count_d;
  logic               fail;

  assign fail = |((y_ref ^ y_dut) & mask_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    dut_a_d     = dut_a_q;
    mismatch_d  = mismatch_q;
    fail_vec_d  = fail_vec_q;
    fail_ref_d  = fail_ref_q;
    fail_dut_d  = fail_dut_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          dut_a_d     = '0;
          mask_d      = care_mask;
          mismatch_d  = 1'b0;
          fail_vec_d  = '0;
          fail_ref_d  = '0;
          fail_dut_d  = '0;
          err_count_d = '0;
        end
      end
      S_APPLY: begin
        if (SETTLE > 0) begin
          state_d = S_WAIT;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CHECK: begin
        if (fail) begin
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          if (!mismatch_q) begin
            fail_vec_d = dut_a_q;
            fail_ref_d = y_ref;
            fail_dut_d = y_dut;
          end
          mismatch_d = 1'b1;
        end
        // All-ones is terminal: the operand is never allowed to wrap.
        if (dut_a_q == '1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_APPLY;
          dut_a_d = dut_a_q + IN_W'(1);
        end
`ifdef STOP_ON_FAIL_EN
        if (fail) begin
          state_d = S_DONE;
          dut_a_d = dut_a_q;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any update computed above, including a CHECK in the same cycle.
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      cnt_d       = cnt_q;
      dut_a_d     = dut_a_q;
      mismatch_d  = mismatch_q;
      fail_vec_d  = fail_vec_q;
      fail_ref_d  = fail_ref_q;
      fail_dut_d  = fail_dut_q;
      err_count_d = err_count_q;
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      dut_a_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      fail_vec_q  <= '0;
      fail_ref_q  <= '0;
      fail_dut_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      dut_a_q     <= dut_a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      fail_vec_q  <= fail_vec_d;
      fail_ref_q  <= fail_ref_d;
      fail_dut_q  <= fail_dut_d;
      err_count_q <= err_count_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign fail_vec  = fail_vec_q;
  assign fail_ref  = fail_ref_q;
  assign fail_dut  = fail_dut_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// tb/tb_vector_sweep_ctrl.sv - scoreboard bench for vector_sweep_ctrl (IN_W=4/SETTLE=1 and IN_W=2/SETTLE=0)
module tb_vector_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        mm;
    logic [7:0]  fv;
    logic [15:0] fr;
    logic [15:0] fd;
    logic [15:0] ec;
    int          cycles;
    int          last;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [15:0] ref_fn(input logic [7:0] v);
    return 16'h3C5A + {8'h00, v} * 16'h1021;
  endfunction

  // DUT A: IN_W=4, SETTLE=1
  logic        start4 = 1'b0, abort4 = 1'b0;
  logic [15:0] mask4 = 16'hFFFF;
  logic [15:0] yref4, ydut4;
  logic [3:0]  a4, fv4;
  logic        busy4, done4, mm4;
  logic [15:0] fr4, fd4, ec4;
  logic [15:0] err4 [16];
  int          done_cnt4 = 0;

  assign yref4 = ref_fn({4'h0, a4});
  assign ydut4 = yref4 ^ err4[a4];

  vector_sweep_ctrl #(.IN_W(4), .OUT_W(16), .SETTLE(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .care_mask(mask4),
    .y_ref(yref4), .y_dut(ydut4), .dut_a(a4), .busy(busy4), .done(done4),
    .mismatch(mm4), .fail_vec(fv4), .fail_ref(fr4), .fail_dut(fd4), .err_count(ec4)
  );

  // DUT B: IN_W=2, SETTLE=0
  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [15:0] mask2 = 16'hFFFF;
  logic [15:0] yref2, ydut2;
  logic [1:0]  a2, fv2;
  logic        busy2, done2, mm2;
  logic [15:0] fr2, fd2, ec2;
  logic [15:0] err2 [16];
  int          done_cnt2 = 0;

  assign yref2 = ref_fn({6'h00, a2});
  assign ydut2 = yref2 ^ err2[{2'b00, a2}];

  vector_sweep_ctrl #(.IN_W(2), .OUT_W(16), .SETTLE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .care_mask(mask2),
    .y_ref(yref2), .y_dut(ydut2), .dut_a(a2), .busy(busy2), .done(done2),
    .mismatch(mm2), .fail_vec(fv2), .fail_ref(fr2), .fail_dut(fd2), .err_count(ec2)
  );

  always @(negedge clk) begin
    if (done4) done_cnt4++;
    if (done2) done_cnt2++;
  end

  function automatic exp_t model(input int nvec, input int settle, input logic [15:0] mask,
                                 input logic [15:0] err [16]);
    exp_t e;
    logic [15:0] r, d;
    e.mm = 1'b0; e.fv = '0; e.fr = '0; e.fd = '0; e.ec = '0;
    e.cycles = nvec * (settle + 2);
    e.last = nvec - 1;
    for (int v = 0; v < nvec; v++) begin
      r = ref_fn(8'(v));
      d = r ^ err[v];
      if (|((r ^ d) & mask)) begin
        if (!e.mm) begin e.mm = 1'b1; e.fv = 8'(v); e.fr = r; e.fd = d; end
        if (e.ec != 16'hFFFF) e.ec = e.ec + 16'd1;
`ifdef STOP_ON_FAIL_EN
        e.cycles = (v + 1) * (settle + 2);
        e.last = v;
        break;
`endif
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run4(input string tag, input logic [15:0] mask);
    exp_t e;
    int cyc, d0;
    sbq.push_back(model(16, 1, mask, err4));
    d0 = done_cnt4;
    mask4 = mask;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    mask4 = 16'h0000;
    check({tag, "_busy_first"}, busy4, 1);
    check({tag, "_a_first"}, a4, 0);
    check({tag, "_mm_cleared"}, mm4, 0);
    check({tag, "_ec_cleared"}, ec4, 0);
    cyc = 0;
    while (busy4 && cyc < 1000) begin cyc++; @(negedge clk); end
    check({tag, "_done"}, done4, 1);
    e = sbq.pop_front();
    check({tag, "_cycles"}, cyc, e.cycles);
    check({tag, "_mm"}, mm4, e.mm);
    check({tag, "_fv"}, fv4, e.fv);
    check({tag, "_fr"}, fr4, e.fr);
    check({tag, "_fd"}, fd4, e.fd);
    check({tag, "_ec"}, ec4, e.ec);
    check({tag, "_a_last"}, a4, e.last);
    @(negedge clk);
    check({tag, "_done_low"}, done4, 0);
    check({tag, "_busy_low"}, busy4, 0);
    check({tag, "_done_pulses"}, done_cnt4 - d0, 1);
  endtask

  task automatic run2(input string tag);
    exp_t e;
    int cyc, d0;
    sbq.push_back(model(4, 0, 16'hFFFF, err2));
    d0 = done_cnt2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 1000) begin
      cyc++;
      start2 = (cyc == 3);
      @(negedge clk);
    end
    start2 = 1'b0;
    e = sbq.pop_front();
    check({tag, "_done"}, done2, 1);
    check({tag, "_cycles"}, cyc, e.cycles);
    check({tag, "_mm"}, mm2, e.mm);
    check({tag, "_fv"}, fv2, e.fv);
    check({tag, "_ec"}, ec2, e.ec);
    check({tag, "_a_last"}, a2, e.last);
    @(negedge clk);
    check({tag, "_busy_low"}, busy2, 0);
    check({tag, "_done_pulses"}, done_cnt2 - d0, 1);
  endtask

  initial begin
    exp_t e;
    int cyc, d0;
    for (int i = 0; i < 16; i++) begin err4[i] = '0; err2[i] = '0; end

    @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_mm", mm4, 0);
    check("rst_ec", ec4, 0);
    check("rst_fv", fv4, 0);
    check("rst_fr", fr4, 0);
    check("rst_fd", fd4, 0);
    check("rst_a", a4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run4("clean", 16'hFFFF);

    err4[5] = 16'h0001;
    err4[9] = 16'h0001;
    run4("two_fail", 16'hFFFF);

    for (int i = 0; i < 16; i++) err4[i] = '0;
    err4[2] = 16'h0008;
    err4[11] = 16'h0008;
    run4("masked", 16'hFFF7);

    // abort in WAIT of vector 7, with failures at 5 (seen) and 9 (never reached)
    for (int i = 0; i < 16; i++) err4[i] = '0;
    err4[5] = 16'h0001;
    err4[9] = 16'h0001;
    sbq.push_back(model(7, 1, 16'hFFFF, err4));
    d0 = done_cnt4;
    mask4 = 16'hFFFF;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (a4 != 4'd7 && cyc < 1000) begin cyc++; @(negedge clk); end
    check("abort_reach7", a4, 7);
    @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    e = sbq.pop_front();
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_a", a4, 7);
    check("abort_mm", mm4, e.mm);
    check("abort_fv", fv4, e.fv);
    check("abort_ec", ec4, e.ec);
    repeat (4) @(negedge clk);
    check("abort_a_held", a4, 7);
    check("abort_no_done", done_cnt4 - d0, 0);
    for (int i = 0; i < 16; i++) err4[i] = '0;
    run4("restart", 16'hFFFF);

    run2("s0");
    err2[2] = 16'h0100;
    run2("s0_fail");

    // asynchronous reset mid-sweep, checked before any clock edge
    err4[5] = 16'h0001;
    mask4 = 16'hFFFF;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (a4 != 4'd9 && cyc < 1000) begin cyc++; @(negedge clk); end
    check("arst_pre_mm", mm4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_mm", mm4, 0);
    check("arst_ec", ec4, 0);
    check("arst_fv", fv4, 0);
    check("arst_fr", fr4, 0);
    check("arst_fd", fd4, 0);
    check("arst_a", a4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4("post_rst", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sweep_ctrl.md
# vector_sweep_ctrl

Sequencer that exhaustively sweeps the input operand of an expression-under-test, feeds the same vector to a reference instance and a device-under-test instance, waits for outputs to settle, compares them under a care mask, and records the first mismatch plus a running error count. It sits above pairs of combinational expression checkers in the equivalence-testing harness, turning them into a self-checking, synthesizable test.

## Interface
- IN_W, 8, width of the swept operand; sweep covers 0 .. 2^IN_W-1
- OUT_W, 16, width of compared outputs
- SETTLE, 2, wait cycles between applying a vector and sampling (0 allowed)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  cancel sweep; return to IDLE
- care_mask  in  OUT_W  1 = bit participates in compare; sampled at start
- y_ref  in  OUT_W  reference instance output
- y_dut  in  OUT_W  device-under-test output
- dut_a  out  IN_W  vector driven to both instances
- busy  out  1  high in APPLY/WAIT/CHECK
- done  out  1  one-cycle pulse at sweep completion
- mismatch  out  1  sticky: at least one failing vector this sweep
- fail_vec  out  IN_W  first failing vector
- fail_ref  out  OUT_W  y_ref captured at first failure
- fail_dut  out  OUT_W  y_dut captured at first failure
- err_count  out  16  failing vectors this sweep, saturates at 16'hFFFF

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE: start=1 -> APPLY; dut_a<=0, mismatch/err_count/fail_* cleared, care_mask latched.
- APPLY (1 cycle): dut_a stable; -> WAIT if SETTLE>0, else CHECK; settle counter loaded with SETTLE-1.
- WAIT: counter decrements; at 0 -> CHECK.
- CHECK (1 cycle): fail = |((y_ref ^ y_dut) & mask). On fail: err_count+1 (saturating); if mismatch was 0, capture dut_a, y_ref, y_dut into fail_*; mismatch<=1.
  - Then if dut_a == all-ones -> DONE; else dut_a<=dut_a+1 -> APPLY.
- DONE (1 cycle): done=1 -> IDLE.
- Results (mismatch, fail_*, err_count) hold in IDLE until next accepted start.
- abort=1 in any non-IDLE state -> IDLE next edge; done not pulsed; results retain values reached so far; abort has priority over CHECK update in the same cycle.
- start while busy or in DONE: ignored.
- dut_a never wraps: all-ones is terminal, never incremented.

## Timing
- Reset values: state IDLE, dut_a 0, busy 0, done 0, mismatch 0, fail_vec 0, fail_ref 0, fail_dut 0, err_count 0.
- start accepted at edge N -> busy=1 and dut_a=0 from N+1.
- Per vector: SETTLE+2 cycles (APPLY + SETTLE×WAIT + CHECK).
- Full sweep: 2^IN_W × (SETTLE+2) cycles busy, then done high for exactly 1 cycle, busy low during DONE.
- CHECK samples y_ref/y_dut at the edge ending CHECK; updates to mismatch/err_count/fail_* visible the following cycle.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- STOP_ON_FAIL_EN defined: first failing CHECK goes directly to DONE (done pulsed); dut_a holds the failing vector; err_count = 1.
- Undefined: sweep always runs to all-ones; every failure counted.

## Test plan
- IN_W=4, SETTLE=1, y_dut=y_ref for all vectors, start pulse -> busy 48 cycles, done single pulse, mismatch 0, err_count 0.
- Same, y_dut differs from y_ref for dut_a=5 and 9 (bit 0) -> mismatch 1, fail_vec 5, fail_ref/fail_dut = values at 5, err_count 2.
- Difference only in bit 3 with care_mask=16'hFFF7 -> mismatch 0, err_count 0.
- abort asserted in WAIT of vector 7 -> IDLE next edge, no done, dut_a 7 held, later start restarts from 0 with cleared results.
- SETTLE=0, IN_W=2 -> 8 busy cycles, CHECK follows APPLY directly; start during busy ignored.
- STOP_ON_FAIL_EN defined, failure at vector 3 -> done after CHECK of vector 3, dut_a 3, err_count 1; asynchronous rst_n low mid-sweep -> all outputs to reset values immediately.
